// File: rtl/sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkg
//   Shared constants and types for the parameterised synchronous FIFO.
//   - DEFAULT_* : default parameter values used by sync_fifo_param
//   - clog2     : ceiling log2, used to size pointer and address fields
//   - fifo_status_t / STATUS_RESET : the registered status flags and their
//     value while in reset (empty FIFO)
// ---------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 16;
    localparam int DEFAULT_AE_LEVEL   = 2;

    // Ceiling log2: clog2(16) = 4, clog2(17) = 5, clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Status flags are kept together so they are computed and registered
    // as one unit and can never disagree with each other.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    // An empty FIFO: count is zero, so it is empty and almost empty.
    localparam fifo_status_t STATUS_RESET = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

endpackage : sync_fifo_pkg

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
//   DEPTH x DATA_WIDTH register array with one synchronous write port and
//   one synchronous read port. The read port output register holds its value
//   when rd_en is low, and is the only resettable state here.
//   Ports:
//     clk      - clock, rising edge
//     reset    - asynchronous active-low reset of the read data register
//     wr_en    - write strobe; wr_data is stored at wr_addr
//     wr_addr  - write index
//     wr_data  - write word
//     rd_en    - read strobe; rd_data loads the entry at rd_addr
//     rd_addr  - read index
//     rd_data  - registered read word
// ---------------------------------------------------------------------------
module fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_W     = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; emptiness is tracked by the
    // pointers, so stale contents are never observable and the array can map
    // onto plain flops or RAM without reset routing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A read of the entry being overwritten on the same edge returns the old
    // word, which is what a full FIFO doing read+write needs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : fifo_mem

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//   Single-clock FIFO with registered read data (1-cycle latency), registered
//   status flags, occupancy count and single-cycle overflow/underflow pulses.
//   Pointers carry one extra wrap bit so full and empty are distinguished
//   without a separate counter.
//   Ports:
//     clk          - clock, all state updates on the rising edge
//     reset        - asynchronous active-low reset
//     clear        - synchronous flush; overrides write_en/read_en
//     write_en     - write request (accepted if not full, or full with read)
//     read_en      - read request (accepted if not empty)
//     data_in      - write data
//     out          - registered read data, holds when no read is accepted
//     full, empty, almost_full, almost_empty - registered status
//     count        - occupancy, 0..DEPTH
//     overflow     - pulse: write refused because full and no read
//     underflow    - pulse: read requested while empty
// ---------------------------------------------------------------------------
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = DEFAULT_AE_LEVEL
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    write_en,
    input  logic                    read_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int IDX_W = clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    localparam ptr_t PTR_ONE   = ptr_t'(1);
    localparam ptr_t AF_THRESH = ptr_t'(AF_LEVEL);
    localparam ptr_t AE_THRESH = ptr_t'(AE_LEVEL);

    ptr_t         wr_ptr;
    ptr_t         rd_ptr;
    ptr_t         wr_ptr_nxt;
    ptr_t         rd_ptr_nxt;
    ptr_t         count_nxt;
    fifo_status_t status;
    fifo_status_t status_nxt;
    logic         wr_accept;
    logic         rd_accept;
    logic         overflow_nxt;
    logic         underflow_nxt;

    // -----------------------------------------------------------------------
    // Next-state logic. Status is derived from the next pointers so the
    // registered flags always agree with the registered count.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path leaves one unassigned and no latch is inferred.
        wr_accept     = 1'b0;
        rd_accept     = 1'b0;
        overflow_nxt  = 1'b0;
        underflow_nxt = 1'b0;
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;

        if (clear) begin
            // Flush: requests in this cycle are ignored, no error pulses.
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            // When full, a read on the same edge frees the slot being written.
            rd_accept     = read_en && !status.empty;
            wr_accept     = write_en && (!status.full || read_en);
            overflow_nxt  = write_en && status.full && !read_en;
            underflow_nxt = read_en && status.empty;

            if (wr_accept) begin
                wr_ptr_nxt = wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr_nxt = rd_ptr + PTR_ONE;
            end
        end

        // Modulo-2^PTR_W difference is exact because occupancy never
        // exceeds DEPTH.
        count_nxt = wr_ptr_nxt - rd_ptr_nxt;

        status_nxt.full         = (wr_ptr_nxt[IDX_W-1:0] == rd_ptr_nxt[IDX_W-1:0]) &&
                                  (wr_ptr_nxt[IDX_W] != rd_ptr_nxt[IDX_W]);
        status_nxt.empty        = (wr_ptr_nxt == rd_ptr_nxt);
        status_nxt.almost_full  = (count_nxt >= AF_THRESH);
        status_nxt.almost_empty = (count_nxt <= AE_THRESH);
    end

    // -----------------------------------------------------------------------
    // Control state.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            status    <= STATUS_RESET;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            status    <= status_nxt;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
        end
    end

    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;

    // -----------------------------------------------------------------------
    // Storage. The read port register is the 'out' register: it loads only on
    // an accepted read, so it holds across idle, underflow and clear cycles.
    // -----------------------------------------------------------------------
    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (IDX_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr[IDX_W-1:0]),
        .wr_data (data_in),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr[IDX_W-1:0]),
        .rd_data (out)
    );

endmodule : sync_fifo_param

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
//   Self-checking bench for sync_fifo_param with default parameters
//   (DATA_WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2). A table of single-cycle
//   vectors covers basic ordering, underflow, simultaneous read/write on
//   empty and clear; hand-written sequences cover full/overflow, read+write
//   while full, pointer wrap, threshold sweep, clear at count 8 and an
//   asynchronous mid-burst reset.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       write_en;
    logic       read_en;
    logic [7:0] data_in;
    logic [7:0] out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_fail   = 0;

    sync_fifo_param dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .write_en     (write_en),
        .read_en      (read_en),
        .data_in      (data_in),
        .out          (out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-cycle vector: inputs, then expected outputs after the edge.
    typedef struct {
        logic       clr;
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [7:0] e_out;
        logic [4:0] e_cnt;
        logic       e_full;
        logic       e_empty;
        logic       e_af;
        logic       e_ae;
        logic       e_ovf;
        logic       e_unf;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] model_q[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_state(input string tag, input logic [7:0] e_out, input logic [4:0] e_cnt,
                               input logic e_full, input logic e_empty, input logic e_af,
                               input logic e_ae, input logic e_ovf, input logic e_unf);
        check({tag, ".out"},          32'(out),          32'(e_out));
        check({tag, ".count"},        32'(count),        32'(e_cnt));
        check({tag, ".full"},         32'(full),         32'(e_full));
        check({tag, ".empty"},        32'(empty),        32'(e_empty));
        check({tag, ".almost_full"},  32'(almost_full),  32'(e_af));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(e_ae));
        check({tag, ".overflow"},     32'(overflow),     32'(e_ovf));
        check({tag, ".underflow"},    32'(underflow),    32'(e_unf));
    endtask

    task automatic drive(input logic clr, input logic wr, input logic rd, input logic [7:0] din);
        clear    = clr;
        write_en = wr;
        read_en  = rd;
        data_in  = din;
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the test is fixed-length, so this only fires on a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_data;
        logic [7:0] last_out;

        // ----------------------------------------------------------------
        // Vector table.  clr wr rd din | out cnt full empty af ae ovf unf
        // ----------------------------------------------------------------
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00, 8'h00,5'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0}); // idle after reset
        vecs.push_back('{1'b0,1'b1,1'b0,8'h11, 8'h00,5'd1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0}); // first write
        vecs.push_back('{1'b0,1'b1,1'b0,8'h22, 8'h00,5'd2,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,8'h33, 8'h00,5'd3,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0}); // count 3: ae drops
        vecs.push_back('{1'b0,1'b0,1'b1,8'h00, 8'h11,5'd2,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,8'h00, 8'h22,5'd1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,8'h00, 8'h33,5'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0}); // drained
        vecs.push_back('{1'b0,1'b0,1'b1,8'h00, 8'h33,5'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1}); // underflow, out holds
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00, 8'h33,5'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0}); // pulse is one cycle
        vecs.push_back('{1'b0,1'b1,1'b1,8'h44, 8'h33,5'd1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1}); // rd+wr on empty
        vecs.push_back('{1'b0,1'b0,1'b1,8'h00, 8'h44,5'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,8'h55, 8'h44,5'd1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b1,8'h66, 8'h44,5'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0}); // clear wins
        vecs.push_back('{1'b0,1'b0,1'b1,8'h00, 8'h44,5'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1}); // 0x55 flushed
        vecs.push_back('{1'b0,1'b1,1'b0,8'h77, 8'h44,5'd1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,8'h00, 8'h77,5'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0});

        // ---------------- Reset state ----------------
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        #12;
        check_state("reset", 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // ---------------- Table-driven vectors ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clr, vecs[i].wr, vecs[i].rd, vecs[i].din);
            step();
            check_state($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_cnt, vecs[i].e_full,
                        vecs[i].e_empty, vecs[i].e_af, vecs[i].e_ae, vecs[i].e_ovf, vecs[i].e_unf);
        end
        last_out = 8'h77;

        // ---------------- Fill to full, then overflow ----------------
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h80 + 8'(i));
            step();
            check($sformatf("fill%0d.count", i), 32'(count), i + 1);
        end
        check_state("full", last_out, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'hEE);
        step();
        check_state("overflow", last_out, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        step();
        check("overflow_clears", 32'(overflow), 32'd0);

        // ---------------- Read+write while full ----------------
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 1'b1, 8'hA0 + 8'(k));
            step();
            check($sformatf("rw_full%0d.out", k), 32'(out), 32'(8'h80 + 8'(k)));
            check($sformatf("rw_full%0d.count", k), 32'(count), 32'd16);
            check($sformatf("rw_full%0d.full", k), 32'(full), 32'd1);
            check($sformatf("rw_full%0d.overflow", k), 32'(overflow), 32'd0);
        end

        // Drain: 0x84..0x8F then 0xA0..0xA3; 0xEE must not appear.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'h00);
            step();
            exp_data = (i < 12) ? 8'h84 + 8'(i) : 8'hA0 + 8'(i - 12);
            check($sformatf("drain%0d.out", i), 32'(out), 32'(exp_data));
        end
        check_state("drained", 8'hA3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // ---------------- Pointer wrap: 40 words through the ring ----------------
        for (int round = 0; round < 4; round++) begin
            for (int j = 0; j < 10; j++) begin
                exp_data = 8'((round * 10 + j) * 7 + 3);
                model_q.push_back(exp_data);
                drive(1'b0, 1'b1, 1'b0, exp_data);
                step();
            end
            for (int j = 0; j < 10; j++) begin
                drive(1'b0, 1'b0, 1'b1, 8'h00);
                step();
                exp_data = model_q.pop_front();
                check($sformatf("wrap%0d_%0d.out", round, j), 32'(out), 32'(exp_data));
            end
        end
        check("wrap_end.empty", 32'(empty), 32'd1);
        check("wrap_end.count", 32'(count), 32'd0);

        // ---------------- Threshold sweep 0..16 ----------------
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        for (int c = 0; c <= 16; c++) begin
            check($sformatf("sweep%0d.count", c), 32'(count), c);
            check($sformatf("sweep%0d.almost_empty", c), 32'(almost_empty), (c <= 2) ? 1 : 0);
            check($sformatf("sweep%0d.almost_full", c), 32'(almost_full), (c >= 14) ? 1 : 0);
            check($sformatf("sweep%0d.full", c), 32'(full), (c == 16) ? 1 : 0);
            check($sformatf("sweep%0d.empty", c), 32'(empty), (c == 0) ? 1 : 0);
            if (c < 16) begin
                drive(1'b0, 1'b1, 1'b0, 8'(c));
                step();
            end
        end
        for (int c = 0; c < 16; c++) begin
            drive(1'b0, 1'b0, 1'b1, 8'h00);
            step();
            check($sformatf("sweep_drain%0d.out", c), 32'(out), c);
        end
        last_out = 8'h0F;

        // ---------------- Clear at count 8 ----------------
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'hC0 + 8'(i));
            step();
        end
        check("pre_clear.count", 32'(count), 32'd8);
        drive(1'b1, 1'b1, 1'b1, 8'hFF);
        step();
        check_state("clear", last_out, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        step();
        check("post_clear.underflow", 32'(underflow), 32'd1);
        check("post_clear.out", 32'(out), 32'(last_out));

        // ---------------- Asynchronous reset mid-burst ----------------
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'hD0 + 8'(i));
            step();
        end
        drive(1'b0, 1'b1, 1'b1, 8'hE0);
        step();
        drive(1'b0, 1'b1, 1'b1, 8'hE1);
        step();
        check("pre_reset.out", 32'(out), 32'h0000_00D1);
        check("pre_reset.full", 32'(full), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        check_state("async_reset", 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // First write accepted on first edge after release; old data gone.
        drive(1'b0, 1'b1, 1'b0, 8'h5A);
        @(negedge clk);
        reset = 1'b1;
        step();
        check("first_write.count", 32'(count), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        step();
        check_state("after_reset_read", 8'h5A, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("after_reset.underflow", 32'(underflow), 32'd1);
        check("after_reset.out", 32'(out), 32'h0000_005A);

        drive(1'b0, 1'b0, 1'b0, 8'h00);
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sync_fifo_param

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the number of entries; legal values are powers of two, at least 2.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, meaning the count at or above which almost_full asserts.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, meaning the count at or below which almost_empty asserts.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit; it SHALL be an asynchronous, active-low reset.
REQ-007 The block SHALL have port clear, input, 1 bit, a synchronous flush.
REQ-008 The block SHALL have port write_en, input, 1 bit, the write request.
REQ-009 The block SHALL have port read_en, input, 1 bit, the read request.
REQ-010 The block SHALL have port data_in, input, DATA_WIDTH bits, the write data.
REQ-011 The block SHALL have port out, output, DATA_WIDTH bits, the registered read data.
REQ-012 The block SHALL have ports full, empty, almost_full and almost_empty, each an output of 1 bit, giving status.
REQ-013 The block SHALL have port count, output, clog2(DEPTH)+1 bits, the current occupancy.
REQ-014 The block SHALL have ports overflow and underflow, each an output of 1 bit, a single-cycle error pulse.

Function
REQ-015 A write SHALL be accepted when write_en=1 and either (full=0) or (full=1 and read_en=1); the accepted word SHALL be stored at the write pointer, and the write pointer SHALL increment.
REQ-016 A read SHALL be accepted when read_en=1 and empty=0; out SHALL take the head entry on that same clock edge, giving 1-cycle latency, and the read pointer SHALL increment.
REQ-017 When no read is accepted, out SHALL hold its previous value.
REQ-018 Pointers SHALL be clog2(DEPTH)+1 bits wide with an extra wrap bit; the index SHALL be the low bits and SHALL wrap from DEPTH-1 to 0.
REQ-019 full SHALL be 1 when the pointer indices are equal and the wrap bits differ; empty SHALL be 1 when the pointers are fully equal.
REQ-020 count SHALL equal write pointer minus read pointer, modulo 2^(clog2(DEPTH)+1), and SHALL range from 0 to DEPTH.
REQ-021 Simultaneous accepted read and write SHALL leave count unchanged; this SHALL be legal when full.
REQ-022 When empty, simultaneous read_en and write_en SHALL accept only the write, and underflow SHALL pulse.
REQ-023 overflow SHALL pulse for 1 cycle when write_en=1, full=1 and read_en=0; the data SHALL be dropped and the state SHALL be unchanged.
REQ-024 underflow SHALL pulse for 1 cycle when read_en=1 and empty=1; out SHALL hold.
REQ-025 almost_full SHALL equal (count >= AF_LEVEL) and almost_empty SHALL equal (count <= AE_LEVEL); all status outputs SHALL be registered and consistent with count in the same cycle.
REQ-026 clear=1 SHALL, at the clock edge, zero both pointers and count, set empty=1 and almost_empty=1, and ignore write_en and read_en in that cycle; out SHALL hold.

Reset
REQ-027 While reset=0, the block SHALL asynchronously clear the pointers, count, out (to 0), full, almost_full, overflow and underflow, and set empty=1 and almost_empty=1.
REQ-028 Storage array contents SHALL NOT be reset.
REQ-029 Reset asserted mid-operation SHALL discard all stored data.
REQ-030 The first write SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-031 Package sync_fifo_pkg SHALL hold the default parameter constants and the pointer-width function clog2.
REQ-032 Sub-module fifo_mem SHALL implement the DEPTH x DATA_WIDTH register array, with 1 synchronous write port and 1 synchronous read port; control logic SHALL stay in sync_fifo_param.

Verification
REQ-033 Reset, then write 0x11, 0x22, 0x33, then 3 reads -> out = 0x11, 0x22, 0x33 on successive cycles after each read edge; empty=1 and count=0 at the end.
REQ-034 With DEPTH=16, write 16 words, then one more -> full=1 and count=16; the 17th write pulses overflow=1 for 1 cycle and is not stored.
REQ-035 From full, drive read_en=1 and write_en=1 for 4 cycles -> count stays 16, and out returns the oldest words in order.
REQ-036 From empty, drive read_en=1 -> underflow pulses and out holds; then fill and drain 40 words -> pointer wrap-around preserves data order.
REQ-037 With count=8, drive clear=1 -> next cycle count=0 and empty=1; drive reset=0 mid-burst -> outputs take reset values immediately, without waiting for clk.
REQ-038 Sweep count 0..16 -> almost_empty=1 only for count<=2, and almost_full=1 only for count>=14.
